// File: rtl/matrix_pkg.sv
// Constants and unload-state encoding shared by the serial matrix loaders and unloaders.
package matrix_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = 4;
  localparam int unsigned MAT_W     = WORD_W * NUM_WORDS;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } unload_state_t;

endpackage

// File: rtl/matrix_c_unloader.sv
// Captures a parallel result matrix in one cycle and streams it out word 0 first
// over a valid/ready interface.
module matrix_c_unloader #(
  parameter int unsigned WORD_W    = matrix_pkg::WORD_W,
  parameter int unsigned NUM_WORDS = matrix_pkg::NUM_WORDS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        C_opcode,
  input  logic [WORD_W*NUM_WORDS-1:0] Data_in,
  input  logic                        Out_ready,
  output logic [WORD_W-1:0]           Data_out,
  output logic                        Out_valid,
  output logic                        Out_last,
  output logic                        Busy_C,
  output logic                        Done_C,
  output logic                        Load_err
);

  import matrix_pkg::*;

  localparam int unsigned     IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  unload_state_t                 state_q, state_d;
  logic [WORD_W*NUM_WORDS-1:0]   shadow_q;
  logic [IDX_W-1:0]              read_index_q;
  logic                          last_word;
  logic                          xfer;

  always_comb begin
    last_word = (read_index_q == LAST_IDX);
    xfer      = (state_q == SEND) && Out_ready;
    state_d   = state_q;
    unique case (state_q)
      IDLE: if (C_opcode) state_d = SEND;
      SEND: if (xfer && last_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Data_out is forced to zero outside SEND so idle/reset always present a clean bus.
  always_comb begin
    Out_valid = (state_q == SEND);
    Busy_C    = (state_q == SEND);
    Out_last  = Out_valid && last_word;
    Data_out  = Out_valid ? shadow_q[32'(read_index_q) * WORD_W +: WORD_W] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q     <= '0;
      read_index_q <= '0;
      Done_C       <= 1'b0;
      Load_err     <= 1'b0;
    end else begin
      Done_C   <= 1'b0;
      Load_err <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (C_opcode) begin
            shadow_q     <= Data_in;
            read_index_q <= '0;
          end
        end
        SEND: begin
          // A load request during an unload is rejected, even on the final transfer.
          Load_err <= C_opcode;
          if (xfer) begin
            if (last_word) begin
              read_index_q <= '0;
              Done_C       <= 1'b1;
            end else begin
              read_index_q <= read_index_q + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_c_unloader.sv
// Randomized self-checking bench for matrix_c_unloader against a queue-based model.
module tb_matrix_c_unloader;

  logic         clk;
  logic         reset;
  logic         C_opcode;
  logic [127:0] Data_in;
  logic         Out_ready;
  logic [31:0]  Data_out;
  logic         Out_valid;
  logic         Out_last;
  logic         Busy_C;
  logic         Done_C;
  logic         Load_err;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  matrix_c_unloader #(.WORD_W(32), .NUM_WORDS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .C_opcode  (C_opcode),
    .Data_in   (Data_in),
    .Out_ready (Out_ready),
    .Data_out  (Data_out),
    .Out_valid (Out_valid),
    .Out_last  (Out_last),
    .Busy_C    (Busy_C),
    .Done_C    (Done_C),
    .Load_err  (Load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {data, valid, last, busy, done, err}.
  logic [36:0] dut_vec;
  assign dut_vec = {Data_out, Out_valid, Out_last, Busy_C, Done_C, Load_err};

  // Reference model: words still owed to the consumer, plus the two pulse flags.
  logic [31:0] mq[$];
  bit          m_done;
  bit          m_err;

  function automatic logic [36:0] exp_vec();
    logic [31:0] d;
    bit v;
    v = (mq.size() > 0);
    d = v ? mq[0] : 32'h0;
    return {d, v, (mq.size() == 1), v, m_done, m_err};
  endfunction

  function automatic logic [127:0] rand_mat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_done = 0;
    m_err  = 0;
  endtask

  task automatic step(input logic op, input logic [127:0] din, input logic rdy);
    @(negedge clk);
    C_opcode  = op;
    Data_in   = din;
    Out_ready = rdy;
    @(posedge clk);
    m_done = 0;
    if (mq.size() == 0) begin
      m_err = 0;
      if (op) for (int i = 0; i < 4; i++) mq.push_back(din[32*i +: 32]);
    end else begin
      m_err = op;
      if (rdy) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_done = 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    C_opcode  = 1'b0;
    Out_ready = 1'b0;
    Data_in   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if (dut_vec !== 37'h0) begin
      miscompares++;
      $display("FAIL reset: got %h exp %h", dut_vec, 37'h0);
    end
  endtask

  task automatic test_basic();
    logic [127:0] pat;
    pat = 128'h44444444_33333333_22222222_11111111;
    for (int c = 0; c < 6; c++) begin
      step(c == 0, (c == 0) ? pat : rand_mat(), 1'b1);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL basic c%0d: got %h exp %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_stall();
    logic [127:0] pat;
    int unsigned dones;
    pat   = 128'h44444444_33333333_22222222_11111111;
    dones = 0;
    for (int c = 0; c < 16; c++) begin
      step(c == 0, (c == 0) ? pat : rand_mat(), (c % 4 == 0) || (c % 4 == 3));
      if (Done_C === 1'b1) dones++;
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL stall c%0d: got %h exp %h", c, dut_vec, exp_vec());
      end
    end
    vectors++;
    if (dones != 1) begin
      miscompares++;
      $display("FAIL stall_done_count: got %0d exp 1", dones);
    end
  endtask

  task automatic test_load_err();
    for (int c = 0; c < 7; c++) begin
      step((c == 0) || (c == 2), rand_mat(), 1'b1);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL load_err c%0d: got %h exp %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_done_reload();
    // Load at c0, four transfers, Done_C visible after c4; reload at c5.
    for (int c = 0; c < 11; c++) begin
      step((c == 0) || (c == 5), rand_mat(), 1'b1);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL done_reload c%0d: got %h exp %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      step(c == 0, rand_mat(), 1'b1);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (dut_vec !== 37'h0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got %h exp %h", dut_vec, 37'h0);
    end
    @(negedge clk);
    C_opcode = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step(c == 2, rand_mat(), 1'b1);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_mid c%0d: got %h exp %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_final_err();
    // Load at c0; c4 is the final-transfer cycle and also requests a load.
    for (int c = 0; c < 8; c++) begin
      step((c == 0) || (c == 4), rand_mat(), 1'b1);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL final_err c%0d: got %h exp %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 5) == 0, rand_mat(), $urandom_range(0, 2) != 0);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL random c%0d: got %h exp %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    C_opcode  = 1'b0;
    Out_ready = 1'b0;
    Data_in   = '0;
    model_reset();
    test_reset();
    test_basic();
    test_stall();
    test_load_err();
    test_done_reload();
    test_reset_mid();
    test_final_err();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
